// File: rtl/split_pkg.sv
// Shared constants for the split buffer: default geometry and the distribution mode encodings.
package split_pkg;

    localparam int unsigned SPLIT_MODE_BROADCAST   = 0;
    localparam int unsigned SPLIT_MODE_ROUND_ROBIN = 1;

    localparam int unsigned SPLIT_DEF_DATA_WIDTH  = 16;
    localparam int unsigned SPLIT_DEF_NUM_OUTPUTS = 2;
    localparam int unsigned SPLIT_DEF_DEPTH       = 4;
    localparam int unsigned SPLIT_DEF_MODE        = SPLIT_MODE_BROADCAST;

endpackage

// File: rtl/split_fifo_channel.sv
// Single-clock FIFO for one output channel; head word is read straight from storage registers.
module split_fifo_channel #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  full;
    logic                  push_ok;
    logic                  pop_ok;

    // A full FIFO refuses a push even when it is popped in the same cycle.
    always_comb begin
        push_ok    = push && !full;
        pop_ok     = pop && !empty;
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CNT_W'(1);
        end
        full_next_c = (count_next == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= full_next_c;
            empty <= (count_next == '0);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/split_buffered_module.sv
// One-to-N token splitter with per-channel FIFOs, broadcast or round-robin distribution.
// Optional counters tokens_accepted/stall_cycles are enabled by defining SPLIT_BUFFERED_STATS_EN.
module split_buffered_module
    import split_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SPLIT_DEF_DATA_WIDTH,
    parameter int unsigned NUM_OUTPUTS = SPLIT_DEF_NUM_OUTPUTS,
    parameter int unsigned DEPTH       = SPLIT_DEF_DEPTH,
    parameter int unsigned MODE        = SPLIT_DEF_MODE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             entry_1,
    input  logic                              entry_valid,
    output logic                              entry_ready,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] output_data,
    output logic [NUM_OUTPUTS-1:0]            output_valid,
    input  logic [NUM_OUTPUTS-1:0]            output_ready
`ifdef SPLIT_BUFFERED_STATS_EN
    ,
    output logic [31:0]                       tokens_accepted,
    output logic [31:0]                       stall_cycles
`endif
);

    localparam int unsigned RR_W    = $clog2(NUM_OUTPUTS);
    localparam int unsigned RR_SPAN = 1 << RR_W;

    logic                   accept;
    logic                   ready_d;
    logic [RR_W-1:0]        rr_ptr;
    logic [RR_W-1:0]        rr_next;
    logic [NUM_OUTPUTS-1:0] push;
    logic [NUM_OUTPUTS-1:0] empty;
    logic [NUM_OUTPUTS-1:0] full_next;
    logic [RR_SPAN-1:0]     full_next_span;
    logic [RR_SPAN-1:0]     push_span;

    // Ready is registered from next-cycle FIFO fullness, so it never sees output_ready combinationally.
    always_comb begin
        accept         = entry_valid && entry_ready;
        full_next_span = RR_SPAN'(full_next);
        push_span      = '0;
        rr_next        = rr_ptr;
        ready_d        = 1'b0;
        if (accept) begin
            rr_next = (rr_ptr == RR_W'(NUM_OUTPUTS - 1)) ? '0 : rr_ptr + RR_W'(1);
        end
        if (MODE == SPLIT_MODE_BROADCAST) begin
            push_span = {RR_SPAN{accept}};
            ready_d   = ~|full_next;
        end else begin
            push_span[rr_ptr] = accept;
            ready_d           = !full_next_span[rr_next];
        end
        push = push_span[NUM_OUTPUTS-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            entry_ready <= 1'b0;
        end else begin
            rr_ptr      <= rr_next;
            entry_ready <= ready_d;
        end
    end

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_ch
        split_fifo_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push        (push[k]),
            .pop         (output_ready[k]),
            .wr_data     (entry_1),
            .rd_data     (output_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .empty       (empty[k]),
            .full_next_c (full_next[k])
        );
    end

    assign output_valid = ~empty;

`ifdef SPLIT_BUFFERED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tokens_accepted <= '0;
            stall_cycles    <= '0;
        end else begin
            if (accept) begin
                tokens_accepted <= tokens_accepted + 32'd1;
            end
            if (entry_valid && !entry_ready) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/split_buffered_module.md
SPLIT_BUFFERED_MODULE -- requirements
Module: split_buffered_module

Interface
REQ-001 Parameter DATA_WIDTH, default 16, token width in bits.
REQ-002 Parameter NUM_OUTPUTS, default 2, output channel count, range 2..8.
REQ-003 Parameter DEPTH, default 4, per-channel FIFO depth, power of two, >= 2.
REQ-004 Parameter MODE, default 0, 0 = broadcast (copy to all), 1 = round-robin distribute.
REQ-005 clk  input  1  rising-edge clock, sole clock domain.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 entry_1  input  DATA_WIDTH  input token.
REQ-008 entry_valid  input  1  entry_1 holds a token.
REQ-009 entry_ready  output  1  block accepts the token this cycle.
REQ-010 output_data  output  NUM_OUTPUTS*DATA_WIDTH  packed outputs, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 output_valid  output  NUM_OUTPUTS  channel k head token valid.
REQ-012 output_ready  input  NUM_OUTPUTS  consumer k takes head token.

Function
REQ-013 Transfer on any interface SHALL occur only on a clk edge with valid and ready both high.
REQ-014 MODE 0: entry_ready SHALL be high only when no channel FIFO is full; an accepted token SHALL be pushed into every channel FIFO in the same cycle.
REQ-015 MODE 1: entry_ready SHALL be high only when the FIFO of channel rr_ptr is not full; an accepted token SHALL be pushed into that channel only.
REQ-016 rr_ptr SHALL increment by one per accepted token and wrap from NUM_OUTPUTS-1 to 0; it SHALL hold when no token is accepted.
REQ-017 entry_ready SHALL depend only on registered FIFO status and not on output_ready (no combinational ready path).
REQ-018 A full FIFO popped in the same cycle SHALL NOT accept a push that cycle.
REQ-019 Latency: token accepted at edge t SHALL appear on output_data/output_valid after edge t, visible in cycle t+1; no fall-through.
REQ-020 Each channel SHALL pop independently; a pop on an empty channel (output_valid low) SHALL be ignored.
REQ-021 Simultaneous push and pop on a non-full, non-empty channel SHALL leave its occupancy unchanged.
REQ-022 Per-channel token order SHALL be preserved; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 output_data for a channel with output_valid low SHALL hold its last value (don't-care for checking).

Reset
REQ-024 While reset is high: all FIFOs empty, output_valid = 0, output_data = 0, rr_ptr = 0, entry_ready = 0.
REQ-025 entry_ready SHALL rise in the first cycle after reset deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all buffered tokens immediately, independent of clk.

Configuration
REQ-027 Macro SPLIT_BUFFERED_STATS_EN defined: add outputs tokens_accepted (32-bit) and stall_cycles (32-bit); tokens_accepted increments per accepted input token, stall_cycles increments per cycle with entry_valid high and entry_ready low; both wrap at 2^32 and reset to 0.
REQ-028 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Shared package split_pkg SHALL hold the default DATA_WIDTH, NUM_OUTPUTS, DEPTH, MODE constants and the mode encodings SPLIT_MODE_BROADCAST = 0, SPLIT_MODE_ROUND_ROBIN = 1.
REQ-030 One sub-module split_fifo_channel (single synchronous FIFO, DATA_WIDTH x DEPTH, full/empty flags), instantiated NUM_OUTPUTS times via generate.

Verification
REQ-031 MODE 0, defaults: push 16'h1234 then 16'hABCD, output_ready = 2'b11 -> both channels present 1234 in cycle t+1, ABCD in cycle t+2.
REQ-032 MODE 0, output_ready = 2'b01, push 6 tokens -> channel 1 fills after 4, entry_ready low from then on, stall while channel 0 drains; raising output_ready[1] restores entry_ready one cycle later.
REQ-033 MODE 1, NUM_OUTPUTS 3, push 0..6 -> channel 0 gets 0,3,6; channel 1 gets 1,4; channel 2 gets 2,5.
REQ-034 Full channel with simultaneous pop and entry_valid high -> no push that cycle, occupancy goes DEPTH to DEPTH-1, push accepted next cycle.
REQ-035 Reset pulse asserted between clk edges with 3 tokens buffered -> output_valid = 0 immediately, rr_ptr = 0, first post-reset token goes to channel 0.
REQ-036 With SPLIT_BUFFERED_STATS_EN: 10 accepted tokens and 5 blocked cycles -> tokens_accepted = 10, stall_cycles = 5.
